tm1638_burst: RTL and testbench

TM1638_BURST -- requirements
Module: tm1638_burst

---
 rtl/tm1638_burst.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_tm1638_burst.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_burst.sv
// ---------------------------------------------------------------------------
// tm1638_burst
// Burst master for the TM1638 three-wire serial interface. One transaction is
// a strobe-framed command byte followed by up to MAX_BYTES data bytes, either
// written from wr_data or read from dio_in. Bits go out LSB first. Each bit
// is CLK_DIV clk cycles with sclk low, then CLK_DIV cycles with sclk high.
//
// Parameters
//   CLK_DIV    clk cycles per sclk half-period (2..255)
//   MAX_BYTES  maximum data bytes after the command byte; len is clamped
//   READ_GAP   idle clk cycles between command byte and first read bit (>= 1)
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle request, accepted only while busy=0
//   rw, cmd, len transaction type (1=write), command byte, data byte count
//   wr_data      next write byte, consumed in the cycle wr_ready=1
//   wr_ready     one-cycle pulse when wr_data is consumed
//   rd_data      received byte, valid while rd_valid=1
//   rd_valid     one-cycle pulse per received byte
//   busy, done   transaction in progress, one-cycle end-of-transaction pulse
//   stb, sclk    TM1638 strobe and serial clock
//   dio_out      TM1638 data out, dio_oe its output enable
//   dio_in       TM1638 data from the pad
// ---------------------------------------------------------------------------
module tm1638_burst #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned MAX_BYTES = 16,
    parameter int unsigned READ_GAP  = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               rw,
    input  logic [7:0]                         cmd,
    input  logic [$clog2(MAX_BYTES + 1)-1:0]   len,
    input  logic [7:0]                         wr_data,
    output logic                               wr_ready,
    output logic [7:0]                         rd_data,
    output logic                               rd_valid,
    output logic                               busy,
    output logic                               done,
    output logic                               stb,
    output logic                               sclk,
    output logic                               dio_out,
    output logic                               dio_oe,
    input  logic                               dio_in
);

    localparam int unsigned LW   = $clog2(MAX_BYTES + 1);
    localparam int unsigned CMAX = (CLK_DIV > READ_GAP) ? CLK_DIV : READ_GAP;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STB_SETUP = 3'd1,
        S_CMD       = 3'd2,
        S_WR_DATA   = 3'd3,
        S_RD_GAP    = 3'd4,
        S_RD_DATA   = 3'd5,
        S_STB_HOLD  = 3'd6,
        S_STB_GAP   = 3'd7
    } state_t;

    // Control state and its next values
    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;      // cycle within current phase
    logic            phase_q, phase_n;  // 0: sclk low half, 1: sclk high half
    logic [2:0]      bit_q, bit_n;      // bit index within current byte
    logic [LW-1:0]   left_q, left_n;    // data bytes still to transfer
    logic [7:0]      sh_q, sh_n;        // transmit shift register, bit 0 on the wire
    logic [7:0]      rx_q, rx_n;        // receive shift register
    logic            rw_q, rw_n;

    // Next values of the registered outputs
    logic            stb_d, sclk_d, dio_d, dio_oe_d, busy_d, done_d;
    logic            wr_ready_d, rd_valid_d;
    logic [7:0]      rd_data_d;
    logic            dio_q;

    logic            half_end;
    logic [LW-1:0]   len_clamped;

    assign half_end    = (cnt_q == CW'(CLK_DIV - 1));
    assign len_clamped = (len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : len;

    // The first bit of a write byte must be on the wire in the same cycle the
    // byte is handed over, so it bypasses the output register for that cycle.
    assign dio_out = wr_ready ? wr_data[0] : dio_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= 3'd0;
            left_q  <= '0;
            sh_q    <= 8'hFF;
            rx_q    <= 8'h00;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            phase_q <= phase_n;
            bit_q   <= bit_n;
            left_q  <= left_n;
            sh_q    <= sh_n;
            rx_q    <= rx_n;
            rw_q    <= rw_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        phase_n = phase_q;
        bit_n   = bit_q;
        left_n  = left_q;
        sh_n    = sh_q;
        rx_n    = rx_q;
        rw_n    = rw_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_STB_SETUP;
                    cnt_n   = '0;
                    rw_n    = rw;
                    sh_n    = cmd;
                    left_n  = len_clamped;
                end
            end

            S_STB_SETUP: begin
                if (half_end) begin
                    state_n = S_CMD;
                    cnt_n   = '0;
                    phase_n = 1'b0;
                    bit_n   = 3'd0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end

            S_CMD, S_WR_DATA, S_RD_DATA: begin
                if (!half_end) begin
                    cnt_n = cnt_q + CW'(1);
                end else begin
                    cnt_n   = '0;
                    phase_n = ~phase_q;
                    if (phase_q) begin
                        // End of the sclk-high half: sample, then advance bit
                        if (state_q == S_RD_DATA) begin
                            rx_n = {dio_in, rx_q[7:1]};
                        end
                        if (bit_q != 3'd7) begin
                            bit_n = bit_q + 3'd1;
                            sh_n  = {1'b1, sh_q[7:1]};
                        end else begin
                            bit_n = 3'd0;
                            if (state_q == S_CMD) begin
                                if (left_q == '0) begin
                                    state_n = S_STB_HOLD;
                                end else if (rw_q) begin
                                    state_n = S_WR_DATA;
                                end else begin
                                    state_n = S_RD_GAP;
                                end
                            end else begin
                                left_n = left_q - LW'(1);
                                if (left_q == LW'(1)) begin
                                    state_n = S_STB_HOLD;
                                end
                            end
                        end
                    end
                end
            end

            S_RD_GAP: begin
                if (cnt_q == CW'(READ_GAP - 1)) begin
                    state_n = S_RD_DATA;
                    cnt_n   = '0;
                    phase_n = 1'b0;
                    bit_n   = 3'd0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end

            S_STB_HOLD: begin
                if (half_end) begin
                    state_n = S_STB_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end

            S_STB_GAP: begin
                if (half_end) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end

            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        // Write byte handed over in the wr_ready cycle (first cycle of a byte,
        // never a phase end since CLK_DIV >= 2)
        if (wr_ready) begin
            sh_n = wr_data;
        end
    end

    // Output decode from the next state, so every pin is a flop output
    always_comb begin
        stb_d      = 1'b0;
        sclk_d     = 1'b1;
        dio_d      = dio_q;
        dio_oe_d   = 1'b1;
        busy_d     = (state_n != S_IDLE);
        done_d     = 1'b0;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data;

        case (state_n)
            S_IDLE: begin
                stb_d = 1'b1;
                dio_d = 1'b1;
            end
            S_STB_GAP: begin
                stb_d  = 1'b1;
                dio_d  = 1'b1;
                done_d = (cnt_n == CW'(CLK_DIV - 1));
            end
            S_CMD: begin
                sclk_d = phase_n;
                dio_d  = sh_n[0];
            end
            S_WR_DATA: begin
                sclk_d     = phase_n;
                dio_d      = sh_n[0];
                wr_ready_d = (bit_n == 3'd0) && !phase_n && (cnt_n == '0);
            end
            S_RD_GAP: begin
                dio_oe_d = 1'b0;
            end
            S_RD_DATA: begin
                dio_oe_d = 1'b0;
                sclk_d   = phase_n;
            end
            default: begin
            end
        endcase

        // Eighth sample just taken: present the byte next cycle
        if ((state_q == S_RD_DATA) && phase_q && half_end && (bit_q == 3'd7)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rx_n;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb      <= 1'b1;
            sclk     <= 1'b1;
            dio_q    <= 1'b1;
            dio_oe   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            stb      <= stb_d;
            sclk     <= sclk_d;
            dio_q    <= dio_d;
            dio_oe   <= dio_oe_d;
            busy     <= busy_d;
            done     <= done_d;
            wr_ready <= wr_ready_d;
            rd_valid <= rd_valid_d;
            rd_data  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_tm1638_burst.sv
// ---------------------------------------------------------------------------
// tb_tm1638_burst
// Self-checking bench for tm1638_burst: table of directed transactions,
// hand-written busy-start and mid-transaction reset sequences, and random
// transactions compared against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_tm1638_burst;

    localparam int CLK_DIV   = 2;
    localparam int MAX_BYTES = 4;
    localparam int READ_GAP  = 8;
    localparam int LW        = $clog2(MAX_BYTES + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          rw;
    logic [7:0]    cmd;
    logic [LW-1:0] len;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic          stb;
    logic          sclk;
    logic          dio_out;
    logic          dio_oe;
    logic          dio_in;

    tm1638_burst #(
        .CLK_DIV  (CLK_DIV),
        .MAX_BYTES(MAX_BYTES),
        .READ_GAP (READ_GAP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rw      (rw),
        .cmd     (cmd),
        .len     (len),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .busy    (busy),
        .done    (done),
        .stb     (stb),
        .sclk    (sclk),
        .dio_out (dio_out),
        .dio_oe  (dio_oe),
        .dio_in  (dio_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt;
    int total_cnt;

    // Bus observations for the current transaction
    int         stb_low;
    int         oe_low;
    int         done_cnt;
    int         wr_cnt;
    int         glitch;
    int         bitn;
    logic [7:0] cur_byte;
    logic [7:0] wire_q[$];
    logic [7:0] rd_q[$];
    logic       prev_sclk;
    logic       prev_stb;
    logic       prev_dio;

    // Host write source and TM1638 read slave
    logic [7:0] wdat[8];
    logic [7:0] sdat[8];
    int         wr_idx;
    logic       wr_pend;
    int         s_byte;
    int         s_bit;
    logic [7:0] slave_cur;

    typedef struct {
        logic        rw;
        logic [7:0]  cmd;
        int          len;
        logic [31:0] data;       // byte i at [8*i +: 8]
        int          exp_stb;
        int          exp_wire;   // bytes clocked out with dio_oe=1
        int          exp_pulses; // wr_ready pulses (write) or rd_valid pulses (read)
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Bus monitor, host write source and slave, all sampled on the falling edge
    always @(negedge clk) begin
        if (!stb) stb_low++;
        if (!dio_oe) oe_low++;
        if (done) done_cnt++;
        if (wr_ready) wr_cnt++;
        if (rd_valid) rd_q.push_back(rd_data);
        if (!stb && !prev_stb && (dio_out !== prev_dio) && !(prev_sclk && !sclk)) glitch++;
        if (!stb && !prev_sclk && sclk && dio_oe) begin
            cur_byte = {dio_out, cur_byte[7:1]};
            bitn++;
            if (bitn == 8) begin
                wire_q.push_back(cur_byte);
                bitn = 0;
            end
        end
        if (!dio_oe && prev_sclk && !sclk) begin
            slave_cur = (s_byte < 8) ? sdat[s_byte] : 8'hFF;
            dio_in    = slave_cur[s_bit];
            s_bit++;
            if (s_bit == 8) begin
                s_bit = 0;
                s_byte++;
            end
        end
        if (wr_pend) begin
            wr_idx++;
            wr_data = wdat[wr_idx % 8];
        end
        wr_pend   = wr_ready;
        prev_sclk = sclk;
        prev_stb  = stb;
        prev_dio  = dio_out;
    end

    task automatic clear_mon();
        stb_low  = 0;
        oe_low   = 0;
        done_cnt = 0;
        wr_cnt   = 0;
        glitch   = 0;
        bitn     = 0;
        cur_byte = 8'h00;
        wire_q.delete();
        rd_q.delete();
        wr_idx   = 0;
        wr_pend  = 1'b0;
        wr_data  = wdat[0];
        s_byte   = 0;
        s_bit    = 0;
        dio_in   = 1'b1;
    endtask

    // One transaction; optionally pulses a conflicting start extra_at cycles in
    task automatic run_txn(input logic t_rw, input logic [7:0] t_cmd,
                           input logic [LW-1:0] t_len, input int extra_at);
        @(negedge clk); #1;
        clear_mon();
        rw    = t_rw;
        cmd   = t_cmd;
        len   = t_len;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
            @(negedge clk); #1;
            if (c == extra_at) begin
                start = 1'b1;
                rw    = ~t_rw;
                cmd   = 8'hFF;
                len   = LW'(3);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
    endtask

    // Transaction-level model: what the wire and host ports should have shown
    task automatic verify(input string tag, input logic t_rw, input logic [7:0] t_cmd,
                          input int t_len);
        int         n;
        int         exp_stb;
        int         exp_oe;
        logic [7:0] ew[$];
        logic [7:0] er[$];
        n       = (t_len > MAX_BYTES) ? MAX_BYTES : t_len;
        exp_stb = CLK_DIV * (2 + 16 * (1 + n)) + ((!t_rw && n > 0) ? READ_GAP : 0);
        exp_oe  = (!t_rw && n > 0) ? READ_GAP + 16 * CLK_DIV * n : 0;
        ew.push_back(t_cmd);
        for (int i = 0; i < n; i++) begin
            if (t_rw) ew.push_back(wdat[i]);
            else      er.push_back(sdat[i]);
        end
        check({tag, ".stb_low"}, stb_low, exp_stb);
        check({tag, ".oe_low"}, oe_low, exp_oe);
        check({tag, ".wire_bytes"}, wire_q.size(), ew.size());
        for (int i = 0; i < ew.size() && i < wire_q.size(); i++)
            check($sformatf("%s.wire_byte%0d", tag, i), int'(wire_q[i]), int'(ew[i]));
        check({tag, ".wr_ready_cnt"}, wr_cnt, t_rw ? n : 0);
        check({tag, ".rd_valid_cnt"}, rd_q.size(), er.size());
        for (int i = 0; i < er.size() && i < rd_q.size(); i++)
            check($sformatf("%s.rd_byte%0d", tag, i), int'(rd_q[i]), int'(er[i]));
        check({tag, ".done_cnt"}, done_cnt, 1);
        check({tag, ".dio_glitch"}, glitch, 0);
        check({tag, ".busy_after"}, int'(busy), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".stb"}, int'(stb), 1);
        check({tag, ".sclk"}, int'(sclk), 1);
        check({tag, ".dio_out"}, int'(dio_out), 1);
        check({tag, ".dio_oe"}, int'(dio_oe), 1);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".done"}, int'(done), 0);
        check({tag, ".wr_ready"}, int'(wr_ready), 0);
        check({tag, ".rd_valid"}, int'(rd_valid), 0);
        check({tag, ".rd_data"}, int'(rd_data), 0);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        rw        = 1'b0;
        cmd       = 8'h00;
        len       = '0;
        prev_sclk = 1'b1;
        prev_stb  = 1'b1;
        prev_dio  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wdat[i] = 8'h00;
            sdat[i] = 8'h00;
        end
        clear_mon();

        vt[0] = '{1'b1, 8'h40, 0, 32'h0000_0000,  36, 1, 0};
        vt[1] = '{1'b1, 8'hC0, 2, 32'h0000_55AA, 100, 3, 2};
        vt[2] = '{1'b0, 8'h42, 4, 32'h5AFF_0081, 172, 1, 4};
        vt[3] = '{1'b1, 8'hC0, MAX_BYTES + 3, 32'h4433_2211, 164, 5, 4};
        vt[4] = '{1'b0, 8'h42, 0, 32'h0000_0000,  36, 1, 0};
        vt[5] = '{1'b1, 8'h44, 1, 32'h0000_003C,  68, 2, 1};

        #12;
        check_idle("in_reset");
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle("after_reset");

        // Directed table
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 8; i++) begin
                wdat[i] = (i < 4) ? vt[v].data[8*i +: 8] : 8'($urandom);
                sdat[i] = (i < 4) ? vt[v].data[8*i +: 8] : 8'($urandom);
            end
            run_txn(vt[v].rw, vt[v].cmd, LW'(vt[v].len), -1);
            verify($sformatf("vec%0d", v), vt[v].rw, vt[v].cmd, vt[v].len);
            check($sformatf("vec%0d.tbl_stb", v), stb_low, vt[v].exp_stb);
            check($sformatf("vec%0d.tbl_wire", v), wire_q.size(), vt[v].exp_wire);
            check($sformatf("vec%0d.tbl_pulses", v), vt[v].rw ? wr_cnt : rd_q.size(),
                  vt[v].exp_pulses);
        end

        // start while busy must be ignored
        wdat[0] = 8'hAA;
        wdat[1] = 8'h55;
        run_txn(1'b1, 8'hC0, LW'(2), 20);
        verify("busy_start", 1'b1, 8'hC0, 2);
        repeat (60) @(negedge clk);
        #1;
        check("busy_start.no_restart", int'(busy), 0);

        // Asynchronous reset in the middle of the first write data byte
        @(negedge clk); #1;
        clear_mon();
        rw    = 1'b1;
        cmd   = 8'hC0;
        len   = LW'(2);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        repeat (5) @(negedge clk);
        #1;
        check("mid_reset.no_done", done_cnt, 0);
        check("mid_reset.no_rd_valid", rd_q.size(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("mid_reset.no_done_after", done_cnt, 0);
        wdat[0] = 8'hAA;
        wdat[1] = 8'h55;
        run_txn(1'b1, 8'hC0, LW'(2), -1);
        verify("post_reset", 1'b1, 8'hC0, 2);

        // Random transactions
        for (int r = 0; r < 16; r++) begin
            logic       t_rw;
            logic [7:0] t_cmd;
            int         t_len;
            t_rw  = 1'($urandom_range(0, 1));
            t_cmd = 8'($urandom);
            t_len = int'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++) begin
                wdat[i] = 8'($urandom);
                sdat[i] = 8'($urandom);
            end
            run_txn(t_rw, t_cmd, LW'(t_len), -1);
            verify($sformatf("rand%0d", r), t_rw, t_cmd, t_len);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
